// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: reset constants, FSM encoding, IF/ID layout.
package fetch_stage_pkg;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        StFetch  = 2'b00,
        StHeld   = 2'b01,
        StHalted = 2'b10
    } fetch_state_e;

    // One IF/ID entry; the hold buffer uses the same layout.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_2;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla_16b (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_c_in,
    output logic [15:0] o_sum
);

    // Group generate/propagate feed the inter-group carries; bits ripple inside a group.
    always_comb begin
        logic [15:0] v_g;
        logic [15:0] v_p;
        logic [2:0]  v_gg;
        logic [2:0]  v_gp;
        logic [3:0]  v_nc;
        logic [15:0] v_c;
        v_g  = i_a & i_b;
        v_p  = i_a ^ i_b;
        v_gg = '0;
        v_gp = '0;
        v_nc = '0;
        v_c  = '0;
        v_nc[0] = i_c_in;
        for (int k = 0; k < 3; k++) begin
            v_gg[k] = v_g[4*k+3]
                    | (v_p[4*k+3] & v_g[4*k+2])
                    | (v_p[4*k+3] & v_p[4*k+2] & v_g[4*k+1])
                    | (v_p[4*k+3] & v_p[4*k+2] & v_p[4*k+1] & v_g[4*k]);
            v_gp[k] = &v_p[4*k +: 4];
            v_nc[k+1] = v_gg[k] | (v_gp[k] & v_nc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            v_c[4*k] = v_nc[k];
            for (int j = 0; j < 3; j++) begin
                v_c[4*k+j+1] = v_g[4*k+j] | (v_p[4*k+j] & v_c[4*k+j]);
            end
        end
        o_sum = v_p ^ v_c;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, variable-latency memory handshake and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC_P  = RESET_PC,
    parameter logic [15:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_rdata,
    input  logic        i_imem_ready,
    input  logic        i_imem_err,
    output logic [15:0] o_instr_out,
    output logic [15:0] o_pc_2_out,
    output logic        o_valid_out,
    output logic        o_err
);

    localparam ifid_t LP_BUBBLE = '{instr: NOP_INSTR_P, pc_2: 16'h0000, valid: 1'b0};

    fetch_state_e r_state;
    logic [15:0]  r_pc;
    ifid_t        r_ifid;
    ifid_t        r_buf;
    logic         r_err;
    logic [15:0]  w_pc_plus2;

    cla_16b u_pc_inc (
        .i_a    (r_pc),
        .i_b    (16'h0002),
        .i_c_in (1'b0),
        .o_sum  (w_pc_plus2)
    );

    // FSM, PC, IF/ID and hold buffer; redirect > stall > halt > ready in FETCH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StFetch;
            r_pc    <= RESET_PC_P;
            r_ifid  <= LP_BUBBLE;
            r_buf   <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (i_redirect) begin
                        r_ifid <= LP_BUBBLE;
                        if (i_redirect_pc[0]) begin
                            r_err   <= 1'b1;
                            r_state <= StHalted;
                        end else begin
                            r_pc <= i_redirect_pc;
                        end
                    end else if (i_stall) begin
                        if (i_imem_ready) begin
                            if (i_imem_err) begin
                                r_err   <= 1'b1;
                                r_state <= StHalted;
                            end else begin
                                r_buf   <= '{instr: i_imem_rdata, pc_2: w_pc_plus2, valid: 1'b1};
                                r_pc    <= w_pc_plus2;
                                r_state <= StHeld;
                            end
                        end
                    end else if (i_halt) begin
                        r_ifid  <= LP_BUBBLE;
                        r_state <= StHalted;
                    end else if (i_imem_ready) begin
                        if (i_imem_err) begin
                            r_ifid  <= LP_BUBBLE;
                            r_err   <= 1'b1;
                            r_state <= StHalted;
                        end else begin
                            r_ifid <= '{instr: i_imem_rdata, pc_2: w_pc_plus2, valid: 1'b1};
                            r_pc   <= w_pc_plus2;
                        end
                    end else begin
                        r_ifid <= LP_BUBBLE;
                    end
                end
                StHeld: begin
                    if (i_redirect) begin
                        r_ifid <= LP_BUBBLE;
                        r_buf  <= '0;
                        if (i_redirect_pc[0]) begin
                            r_err   <= 1'b1;
                            r_state <= StHalted;
                        end else begin
                            r_pc    <= i_redirect_pc;
                            r_state <= StFetch;
                        end
                    end else if (i_stall) begin
                        r_state <= StHeld;
                    end else if (i_halt) begin
                        r_ifid  <= LP_BUBBLE;
                        r_buf   <= '0;
                        r_state <= StHalted;
                    end else begin
                        r_ifid  <= r_buf;
                        r_buf   <= '0;
                        r_state <= StFetch;
                    end
                end
                StHalted: begin
                    r_ifid <= LP_BUBBLE;
                end
                default: begin
                    r_ifid  <= LP_BUBBLE;
                    r_state <= StHalted;
                end
            endcase
        end
    end

    // Request only while fetching and never while reset is held.
    assign o_imem_req  = (r_state == StFetch) && i_rst_n;
    assign o_imem_addr = r_pc;
    assign o_instr_out = r_ifid.instr;
    assign o_pc_2_out  = r_ifid.pc_2;
    assign o_valid_out = r_ifid.valid;
    assign o_err       = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [15:0] i_redirect_pc = 16'h0;
    logic        i_halt = 1'b0;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic [15:0] i_imem_rdata = 16'h0;
    logic        i_imem_ready = 1'b0;
    logic        i_imem_err = 1'b0;
    logic [15:0] o_instr_out;
    logic [15:0] o_pc_2_out;
    logic        o_valid_out;
    logic        o_err;

    int n_chk = 0;
    int n_err = 0;

    // Model state: what the stage should hold, in plain terms.
    logic [15:0] m_pc;
    logic        m_have_buf;
    logic        m_stopped;
    logic [15:0] m_buf_instr, m_buf_pc2;
    logic [15:0] m_instr, m_pc2;
    logic        m_valid, m_err;

    fetch_stage dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (i_imem_rdata),
        .i_imem_ready  (i_imem_ready),
        .i_imem_err    (i_imem_err),
        .o_instr_out   (o_instr_out),
        .o_pc_2_out    (o_pc_2_out),
        .o_valid_out   (o_valid_out),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_have_buf = 1'b0; m_stopped = 1'b0;
        m_buf_instr = 16'h0; m_buf_pc2 = 16'h0;
        m_instr = NOP_INSTR; m_pc2 = 16'h0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic bubble();
        m_instr = NOP_INSTR; m_pc2 = 16'h0; m_valid = 1'b0;
    endtask

    // One clock of the stage's rules, applied to the model.
    task automatic model_step();
        logic [15:0] nxt;
        nxt = m_pc + 16'd2;
        if (m_stopped) begin
            bubble();
        end else if (m_have_buf) begin
            if (i_redirect) begin
                bubble();
                m_have_buf = 1'b0;
                if (i_redirect_pc[0]) begin m_err = 1'b1; m_stopped = 1'b1; end
                else m_pc = i_redirect_pc;
            end else if (i_stall) begin
                // everything frozen
            end else if (i_halt) begin
                bubble(); m_have_buf = 1'b0; m_stopped = 1'b1;
            end else begin
                m_instr = m_buf_instr; m_pc2 = m_buf_pc2; m_valid = 1'b1;
                m_have_buf = 1'b0;
            end
        end else begin
            if (i_redirect) begin
                bubble();
                if (i_redirect_pc[0]) begin m_err = 1'b1; m_stopped = 1'b1; end
                else m_pc = i_redirect_pc;
            end else if (i_stall) begin
                if (i_imem_ready && i_imem_err) begin
                    m_err = 1'b1; m_stopped = 1'b1;
                end else if (i_imem_ready) begin
                    m_buf_instr = i_imem_rdata; m_buf_pc2 = nxt;
                    m_pc = nxt; m_have_buf = 1'b1;
                end
            end else if (i_halt) begin
                bubble(); m_stopped = 1'b1;
            end else if (i_imem_ready && i_imem_err) begin
                bubble(); m_err = 1'b1; m_stopped = 1'b1;
            end else if (i_imem_ready) begin
                m_instr = i_imem_rdata; m_pc2 = nxt; m_valid = 1'b1; m_pc = nxt;
            end else begin
                bubble();
            end
        end
    endtask

    task automatic check_ifid();
        check("instr", {16'h0, o_instr_out}, {16'h0, m_instr});
        check("pc_2", {16'h0, o_pc_2_out}, {16'h0, m_pc2});
        check("valid", {31'h0, o_valid_out}, {31'h0, m_valid});
        check("err", {31'h0, o_err}, {31'h0, m_err});
    endtask

    // Called at a negedge: drive, check request side, clock, check IF/ID.
    task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc,
                         input logic hl, input logic rdy, input logic [15:0] data,
                         input logic er);
        i_stall = st; i_redirect = rd; i_redirect_pc = rpc; i_halt = hl;
        i_imem_ready = rdy; i_imem_rdata = data; i_imem_err = er;
        #1;
        check("req", {31'h0, o_imem_req}, {31'h0, !(m_have_buf || m_stopped)});
        check("addr", {16'h0, o_imem_addr}, {16'h0, m_pc});
        @(posedge i_clk);
        model_step();
        #1;
        check_ifid();
        @(negedge i_clk);
    endtask

    task automatic idle(input logic rdy, input logic [15:0] data);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, rdy, data, 1'b0);
    endtask

    // Reset asserted from a negedge; state must clear without a clock edge.
    task automatic do_reset();
        i_rst_n = 1'b0;
        i_stall = 1'b0; i_redirect = 1'b0; i_halt = 1'b0; i_imem_ready = 1'b0;
        i_imem_err = 1'b0;
        model_reset();
        #1;
        check("rst_req", {31'h0, o_imem_req}, 32'h0);
        check("rst_addr", {16'h0, o_imem_addr}, {16'h0, RESET_PC});
        check_ifid();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] rpc;
        model_reset();
        @(negedge i_clk);
        do_reset();

        // Back-to-back fetches, then a 3-cycle memory wait at pc=4.
        idle(1'b1, 16'hC001);
        idle(1'b1, 16'hC002);
        repeat (3) idle(1'b0, 16'hDEAD);
        idle(1'b1, 16'h1234);
        idle(1'b1, 16'h5678);
        // Stall while the word at pc=8 returns; buffer drains when stall drops.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hA5A5, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(1'b0, 16'h0);
        idle(1'b1, 16'h7777);
        // Redirect beats a returning word.
        cycle(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        idle(1'b1, 16'h4040);
        // Wrap at the top of the address space.
        cycle(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(1'b1, 16'hFEFE);
        idle(1'b1, 16'h0101);
        // Misaligned redirect faults; later redirect is ignored.
        cycle(1'b0, 1'b1, 16'h0013, 1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h1111, 1'b0);
        do_reset();
        // Memory fault with ready.
        idle(1'b1, 16'hC001);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h9999, 1'b1);
        idle(1'b1, 16'h2222);
        do_reset();
        // Halt is sticky; redirect does not revive the stage.
        idle(1'b1, 16'hC001);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h3333, 1'b0);
        cycle(1'b0, 1'b1, 16'h0080, 1'b0, 1'b1, 16'h4444, 1'b0);
        repeat (2) idle(1'b1, 16'h5555);
        do_reset();
        // Reset in the middle of a pending request.
        idle(1'b1, 16'hC001);
        idle(1'b0, 16'h0);
        do_reset();

        // Randomized episodes.
        for (int ep = 0; ep < 10; ep++) begin
            for (int c = 0; c < 150; c++) begin
                rpc = 16'($urandom) & 16'hFFFE;
                if ($urandom_range(0, 9) == 0) rpc = 16'hFFFE;
                if ($urandom_range(0, 15) == 0) rpc[0] = 1'b1;
                cycle(($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 11) == 0),
                      rpc,
                      ($urandom_range(0, 99) == 0),
                      ($urandom_range(0, 9) < 6),
                      16'($urandom),
                      ($urandom_range(0, 59) == 0));
            end
            do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register; directly upstream of decode.
- Holds the PC and issues requests to a variable-latency instruction memory (req/ready).
- Delivers the instruction word and PC+2 to decode, with stall hold, redirect flush and HALT handling.
- Decode consumes instr_out on its instruction input and pc_2_out on its PC_2 input; decode's deasserted fetch_enable drives halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble word placed in IF/ID (WISC NOP).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- stall  in  1  hazard unit: freeze IF/ID and PC.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  16  target for redirect.
- halt  in  1  decode holds HALT (fetch_enable low).
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address (= pc).
- imem_rdata  in  16  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory completes the request this cycle.
- imem_err  in  1  memory fault, qualified by imem_ready.
- instr_out  out  16  IF/ID instruction.
- pc_2_out  out  16  IF/ID fetched PC + 2.
- valid_out  out  1  IF/ID holds a real instruction.
- err  out  1  sticky fault flag.

Behaviour:
Reset values:
- pc=RESET_PC; state=FETCH.
- instr_out=NOP_INSTR; pc_2_out=0; valid_out=0; err=0; hold buffer cleared.
- Reset takes effect immediately from any state, including mid-request.
- imem_req is 0 while reset is asserted.

State FETCH:
- imem_req=1; imem_addr=pc.
- addr is stable while req=1 and ready=0, unless redirect occurs.

Per-cycle priority in FETCH (highest first):
- redirect:
  - pc<=redirect_pc.
  - Any word returned this cycle is discarded.
  - IF/ID<=bubble (NOP_INSTR, valid 0).
  - Memory treats the changed addr as a new request.
- stall:
  - IF/ID holds its value.
  - If ready: word goes to the hold buffer {rdata, pc+2}; pc<=pc+2; state HELD.
  - Else: no change.
- halt:
  - IF/ID<=bubble; state HALTED; pc unchanged.
  - Any returned word is discarded.
- ready:
  - IF/ID<={imem_rdata, pc+2, valid 1}; pc<=pc+2.
- none of the above (not ready):
  - IF/ID<=bubble; pc unchanged.

State HELD:
- imem_req=0.
- redirect: drop buffer; pc<=redirect_pc; IF/ID<=bubble; go to FETCH.
- stall: hold everything.
- halt: IF/ID<=bubble; drop buffer; go to HALTED.
- Otherwise: IF/ID<=buffer (valid 1); go to FETCH.

State HALTED:
- imem_req=0; IF/ID<=bubble each cycle.
- Sticky until reset; redirect is ignored.

Faults and boundaries:
- A word with imem_ready & imem_err sets err=1, is not loaded, and goes to HALTED.
- redirect with redirect_pc[0]=1 sets err=1 and goes to HALTED.
- pc+2 arithmetic is modulo 2^16: pc 16'hFFFE -> 16'h0000; this is not an error.
- Latency: with ready in the request cycle, the instruction appears in IF/ID the next cycle, giving 1 instruction/cycle sustained.

Decomposition:
- Shared package holds:
  - RESET_PC and NOP_INSTR.
  - State encodings FETCH=2'b00, HELD=2'b01, HALTED=2'b10.
- Use the existing cla_16b for the pc+2 incrementer (b=16'h0002, c_in=0).
- No new sub-module; the FSM, PC and IF/ID registers live in fetch_stage.

Test Plan:
- Reset then imem_ready=1 every cycle, rdata=16'hC001, 16'hC002:
  - imem_addr 0, 2, 4 on consecutive cycles.
  - instr_out=C001/pc_2_out=2 then C002/4; valid_out=1.
- ready delayed 3 cycles at pc=4:
  - imem_addr held at 4; three bubbles (valid 0, instr 0800).
  - Then the word with pc_2_out=6.
- stall high for 2 cycles while ready returns 16'hA5A5 at pc=8:
  - IF/ID unchanged; imem_req=0 in HELD.
  - After stall drops: instr_out=A5A5, pc_2_out=A; next addr=A.
- redirect=1, redirect_pc=16'h0040 in the same cycle as ready:
  - Returned word discarded; bubble in IF/ID; next imem_addr=0040.
- halt asserted:
  - imem_req=0 forever, valid_out=0.
  - A later redirect is ignored; only rst=0 restores addr=RESET_PC.
- pc=FFFE with ready → next addr 0000, err=0.
- redirect_pc=0x0013 → err=1, HALTED.
- imem_err with ready → err=1, no IF/ID load.
